// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky error pending bits, per-source mask, global enable,
// and an interrupt line with minimum hold, hold-until-clear and a cooldown gap.
module irq_ctrl #(
  parameter int N_SRC         = 4,
  parameter int IRQ_HOLD_TIME = 1024,
  parameter int COOLDOWN      = 16
) (
  input  logic             aclk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] err_i,
  input  logic             reg_req_i,
  input  logic             reg_we_i,
  input  logic [1:0]       reg_addr_i,
  input  logic [N_SRC-1:0] reg_wdata_i,
  output logic             reg_ack_o,
  output logic [N_SRC-1:0] reg_rdata_o,
  output logic             irq_o
);

  localparam int MAXV = (IRQ_HOLD_TIME > COOLDOWN) ? IRQ_HOLD_TIME : COOLDOWN;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(IRQ_HOLD_TIME - 1);
  localparam logic [CW-1:0] COOL_LD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSERT   = 2'd1;
  localparam logic [1:0] WAIT_CLR = 2'd2;
  localparam logic [1:0] COOL     = 2'd3;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_MASK   = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N_SRC-1:0] status, mask, clr, rd_mux;
  logic             gen, acc, wr, active;

  // One access per two cycles: a request is only taken while no ack is showing.
  assign acc    = reg_req_i & ~reg_ack_o;
  assign wr     = acc & reg_we_i;
  assign clr    = (wr && reg_addr_i == A_CLEAR) ? reg_wdata_i : '0;
  assign active = gen & (|(status & mask));

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      A_STATUS: rd_mux = status;
      A_MASK:   rd_mux = mask;
      A_CTRL:   rd_mux[0] = gen;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (active) begin
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
        end
      end
      ASSERT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (active) begin
          state_nxt = WAIT_CLR;
        end else if (COOLDOWN == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = COOL;
          cnt_nxt   = COOL_LD;
        end
      end
      WAIT_CLR: begin
        if (!active) begin
          if (COOLDOWN == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = COOL;
            cnt_nxt   = COOL_LD;
          end
        end
      end
      COOL: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (active) begin
          // Pass through IDLE in zero cycles so the low gap is exactly COOLDOWN.
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      irq_o       <= 1'b0;
      reg_ack_o   <= 1'b0;
      reg_rdata_o <= '0;
      status      <= '0;
      mask        <= '0;
      gen         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      irq_o       <= (state_nxt == ASSERT) || (state_nxt == WAIT_CLR);
      reg_ack_o   <= acc;
      reg_rdata_o <= (acc && !reg_we_i) ? rd_mux : '0;
      // New error on the same edge as a clear of that bit keeps it pending.
      status      <= (status & ~clr) | err_i;
      if (wr && reg_addr_i == A_MASK) mask <= reg_wdata_i;
      if (wr && reg_addr_i == A_CTRL) gen  <= reg_wdata_i[0];
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, all checked every
// cycle against a timing-rule model of the interrupt line and register file.
module tb_irq_ctrl;
  localparam int N = 4;
  localparam int H = 1024;
  localparam int C = 16;

  logic         aclk = 1'b0;
  logic         rstn;
  logic [N-1:0] err_i;
  logic         reg_req_i, reg_we_i;
  logic [1:0]   reg_addr_i;
  logic [N-1:0] reg_wdata_i;
  logic         reg_ack_o;
  logic [N-1:0] reg_rdata_o;
  logic         irq_o;

  irq_ctrl #(.N_SRC(N), .IRQ_HOLD_TIME(H), .COOLDOWN(C)) dut (
    .aclk(aclk), .rstn(rstn), .err_i(err_i),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_ack_o(reg_ack_o), .reg_rdata_o(reg_rdata_o),
    .irq_o(irq_o)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: registers, port outputs, and how long the line has been high/low.
  logic [N-1:0] m_status, m_mask, m_rdata;
  logic         m_gen, m_ack, m_irq;
  int           m_high, m_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic         act, acc, nxt;
    logic [N-1:0] clr, rd;
    if (!rstn) begin
      m_status = '0; m_mask = '0; m_gen = 1'b0;
      m_ack = 1'b0; m_rdata = '0; m_irq = 1'b0;
      m_high = 0; m_low = 1 << 20;
    end else begin
      act = m_gen && ((m_status & m_mask) != '0);
      acc = reg_req_i && !m_ack;
      rd  = '0;
      if (acc && !reg_we_i) begin
        if (reg_addr_i == 2'd0) rd = m_status;
        if (reg_addr_i == 2'd1) rd = m_mask;
        if (reg_addr_i == 2'd3) rd = N'(m_gen);
      end
      // High: hold at least H cycles, then follow active. Low: rise once C cycles have passed.
      if (m_irq) nxt = (m_high < H) ? 1'b1 : act;
      else       nxt = act && (m_low >= C);
      if (nxt) begin
        m_high = m_irq ? m_high + 1 : 1;
        m_low  = 0;
      end else begin
        m_low  = m_irq ? 1 : ((m_low < (1 << 20)) ? m_low + 1 : m_low);
        m_high = 0;
      end
      clr      = (acc && reg_we_i && reg_addr_i == 2'd2) ? reg_wdata_i : '0;
      m_status = (m_status & ~clr) | err_i;
      if (acc && reg_we_i && reg_addr_i == 2'd1) m_mask = reg_wdata_i;
      if (acc && reg_we_i && reg_addr_i == 2'd3) m_gen  = reg_wdata_i[0];
      m_ack   = acc;
      m_rdata = rd;
      m_irq   = nxt;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    cyc++;
    #1;
    chk("irq", 32'(irq_o), 32'(m_irq));
    chk("ack", 32'(reg_ack_o), 32'(m_ack));
    chk("rdata", 32'(reg_rdata_o), 32'(m_rdata));
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [N-1:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    tick();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    tick();
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [N-1:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
    tick();
    d = reg_rdata_o;
    reg_req_i = 1'b0;
    tick();
  endtask

  task automatic wait_irq(input string tag, input logic val, input int budget);
    int n;
    n = 0;
    while (irq_o !== val && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(irq_o), 32'(val));
  endtask

  initial begin
    logic [N-1:0] d;
    int rise_cyc, fall_cyc, acks;

    rstn = 1'b0; err_i = '0; reg_req_i = 1'b0; reg_we_i = 1'b0;
    reg_addr_i = '0; reg_wdata_i = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    reg_rd(2'd0, d); chk("rst_status", 32'(d), 32'h0);
    reg_rd(2'd1, d); chk("rst_mask", 32'(d), 32'h0);
    reg_rd(2'd3, d); chk("rst_ctrl", 32'(d), 32'h0);

    reg_wr(2'd1, 4'hF);
    reg_wr(2'd3, 4'hF);
    reg_rd(2'd1, d); chk("mask_rb", 32'(d), 32'hF);
    reg_rd(2'd3, d); chk("ctrl_rb", 32'(d), 32'h1);

    // Error at edge k, clear at k+5: exact minimum hold.
    err_i = 4'b0001;
    tick();
    err_i = '0;
    chk("irq_after_k", 32'(irq_o), 32'h0);
    tick();
    chk("irq_after_k1", 32'(irq_o), 32'h1);
    rise_cyc = cyc;
    reg_rd(2'd0, d); chk("status_k", 32'(d), 32'h1);
    tick();
    reg_wr(2'd2, 4'h1);
    wait_irq("hold_fall", 1'b0, 2000);
    chk("hold_len", 32'(cyc - rise_cyc), 32'(H));

    // No clear: line held past the minimum, then cooldown with a second error pending.
    repeat (C + 4) tick();
    err_i = 4'b0001;
    tick();
    err_i = '0;
    wait_irq("rise2", 1'b1, 10);
    repeat (H + 50) tick();
    chk("hold_past", 32'(irq_o), 32'h1);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 2'd2; reg_wdata_i = 4'h1;
    tick();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    chk("clr_edge_m", 32'(irq_o), 32'h1);
    tick();
    chk("clr_edge_m1", 32'(irq_o), 32'h0);
    fall_cyc = cyc;
    err_i = 4'b0010;
    tick();
    err_i = '0;
    wait_irq("rise_after_cool", 1'b1, 100);
    chk("cool_len", 32'(cyc - fall_cyc), 32'(C));
    reg_wr(2'd2, 4'h2);
    wait_irq("fall3", 1'b0, 2000);

    // Masked source sets STATUS only; unmasking raises the line.
    reg_wr(2'd1, 4'h0);
    repeat (C + 4) tick();
    err_i = 4'b0100;
    tick();
    err_i = '0;
    repeat (3) tick();
    chk("masked_irq", 32'(irq_o), 32'h0);
    reg_rd(2'd0, d); chk("masked_status", 32'(d), 32'h4);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 2'd1; reg_wdata_i = 4'h4;
    tick();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    chk("unmask_w", 32'(irq_o), 32'h0);
    tick();
    chk("unmask_w1", 32'(irq_o), 32'h1);

    // Set and clear of the same bit on one edge: set wins.
    err_i = 4'b0100;
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 2'd2; reg_wdata_i = 4'h4;
    tick();
    err_i = '0; reg_req_i = 1'b0; reg_we_i = 1'b0;
    tick();
    reg_rd(2'd0, d); chk("set_wins", 32'(d), 32'h4);
    reg_wr(2'd2, 4'h4);
    reg_rd(2'd0, d); chk("cleared", 32'(d), 32'h0);

    // Request held 4 cycles: two accesses, on alternate cycles.
    acks = 0;
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 2'd1;
    repeat (4) begin
      tick();
      acks += int'(reg_ack_o);
    end
    reg_req_i = 1'b0;
    tick();
    acks += int'(reg_ack_o);
    chk("b2b_acks", 32'(acks), 32'h2);

    // Reset while the line is held high.
    err_i = 4'b0100;
    tick();
    err_i = '0;
    chk("pre_rst_irq", 32'(irq_o), 32'h1);
    rstn = 1'b0;
    tick();
    chk("rst_irq", 32'(irq_o), 32'h0);
    rstn = 1'b1;
    reg_rd(2'd0, d); chk("rst_status2", 32'(d), 32'h0);

    // Random traffic, enabled so the line cycles through its states.
    reg_wr(2'd1, 4'hF);
    reg_wr(2'd3, 4'h1);
    for (int i = 0; i < 6000; i++) begin
      for (int b = 0; b < N; b++) err_i[b] = ($urandom_range(0, 199) < 2);
      reg_req_i   = ($urandom_range(0, 3) == 0);
      reg_we_i    = $urandom_range(0, 1) == 1;
      reg_addr_i  = 2'($urandom_range(0, 3));
      reg_wdata_i = N'($urandom);
      if (reg_addr_i == 2'd3) reg_wdata_i[0] = ($urandom_range(0, 7) != 0);
      if (reg_addr_i == 2'd1) reg_wdata_i = reg_wdata_i | 4'h1;
      tick();
    end
    err_i = '0; reg_req_i = 1'b0; reg_we_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
